// File: rtl/ysyx_22050854_bp_pkg.sv
// Shared types and constants for the fetch-PC branch predictor.
// BTB entry layout, direction-counter init values, redirect causes.
package ysyx_22050854_bp_pkg;

    localparam int BP_XLEN     = 32;
    localparam int BP_ENTRIES  = 16;
    localparam int BP_CTR_BITS = 2;

    typedef struct packed {
        logic                   valid;
        logic [BP_XLEN-1:0]     tag;
        logic [BP_XLEN-1:0]     target;
        logic                   is_jump;
        logic [BP_CTR_BITS-1:0] ctr;
    } btb_entry_t;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_CSR,
        RD_MISPREDICT
    } redirect_e;

    function automatic int ctr_weak_taken(input int bits);
        return 1 << (bits - 1);
    endfunction

    function automatic int ctr_weak_not_taken(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/ysyx_22050854_pc_bp_btb.sv
// Direct-mapped BTB with saturating direction counters.
// Lookup is combinational; updates land on the next rising edge.
module ysyx_22050854_btb
    import ysyx_22050854_bp_pkg::*;
#(
    parameter int XLEN     = BP_XLEN,
    parameter int ENTRIES  = BP_ENTRIES,
    parameter int CTR_BITS = BP_CTR_BITS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX = $clog2(ENTRIES);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  =
        CTR_BITS'(ctr_weak_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WNT =
        CTR_BITS'(ctr_weak_not_taken(CTR_BITS));

    btb_entry_t mem [ENTRIES];

    logic [IDX-1:0]  l_idx;
    logic [IDX-1:0]  u_idx;
    logic [XLEN-1:0] l_tag;
    logic [XLEN-1:0] u_tag;
    logic            u_hit;
    logic [CTR_BITS-1:0] u_ctr;
    logic            unused_low;

    // Tags are stored zero-extended to full width.
    assign l_idx = lookup_pc[IDX+1:2];
    assign u_idx = upd_pc[IDX+1:2];
    assign l_tag = {{(IDX+2){1'b0}}, lookup_pc[XLEN-1:IDX+2]};
    assign u_tag = {{(IDX+2){1'b0}}, upd_pc[XLEN-1:IDX+2]};

    assign unused_low = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign hit = mem[l_idx].valid && (mem[l_idx].tag == l_tag);
    assign pred_taken = hit &&
        (mem[l_idx].is_jump || mem[l_idx].ctr[CTR_BITS-1]);
    assign target = mem[l_idx].target;

    assign u_hit = mem[u_idx].valid && (mem[u_idx].tag == u_tag);
    assign u_ctr = mem[u_idx].ctr;

    // Allocate on taken miss, train counter on hit, clear all on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0,
                            is_jump: 1'b0, ctr: CTR_WNT};
            end
        end else if (upd_valid) begin
            if (upd_taken && !u_hit) begin
                mem[u_idx] <= '{valid: 1'b1, tag: u_tag,
                                target: upd_target,
                                is_jump: upd_is_jump, ctr: CTR_WT};
            end else if (upd_taken) begin
                mem[u_idx].target  <= upd_target;
                mem[u_idx].is_jump <= upd_is_jump;
                mem[u_idx].ctr     <= (u_ctr == CTR_MAX) ?
                                      u_ctr : u_ctr + 1'b1;
            end else if (u_hit) begin
                mem[u_idx].ctr <= (u_ctr == '0) ?
                                  u_ctr : u_ctr - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_22050854_pc_bp.sv
// Fetch-PC generator: PC register, next-PC mux, mispredict detect.
// Redirects (CSR, mispredict) override stall; CSR wins over mispredict.
module ysyx_22050854_pc_bp
    import ysyx_22050854_bp_pkg::*;
#(
    parameter int              XLEN        = BP_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
    parameter int              BTB_ENTRIES = BP_ENTRIES,
    parameter int              CTR_BITS    = BP_CTR_BITS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            csr_redirect,
    input  logic [XLEN-1:0] csr_pc,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_is_jump,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] res_pred_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            flush,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
);

    logic            mispredict;
    logic [XLEN-1:0] fix_pc;
    logic            unused_hit;
    redirect_e       cause;

    ysyx_22050854_btb #(
        .XLEN     (XLEN),
        .ENTRIES  (BTB_ENTRIES),
        .CTR_BITS (CTR_BITS)
    ) u_btb (
        .clock       (clock),
        .reset       (reset),
        .lookup_pc   (pc),
        .hit         (unused_hit),
        .pred_taken  (pred_taken),
        .target      (pred_target),
        .upd_valid   (res_valid),
        .upd_pc      (res_pc),
        .upd_is_jump (res_is_jump),
        .upd_taken   (res_taken),
        .upd_target  (res_target)
    );

    assign mispredict = res_valid &&
        ((res_taken != res_pred_taken) ||
         (res_taken && (res_target != res_pred_target)));

    assign fix_pc = res_taken ? res_target : res_pc + XLEN'(4);
    assign flush  = csr_redirect || mispredict;

    // Pick the redirect source; CSR beats a same-cycle mispredict.
    always_comb begin
        cause = RD_NONE;
        if (csr_redirect) begin
            cause = RD_CSR;
        end else if (mispredict) begin
            cause = RD_MISPREDICT;
        end
    end

    // Next-PC mux: reset, redirect, stall, prediction, sequential.
    always_comb begin
        next_pc = pc + XLEN'(4);
        if (reset) begin
            next_pc = RESET_PC;
        end else begin
            case (cause)
                RD_CSR:        next_pc = csr_pc;
                RD_MISPREDICT: next_pc = fix_pc;
                default: begin
                    if (stall) begin
                        next_pc = pc;
                    end else if (pred_taken) begin
                        next_pc = pred_target;
                    end
                end
            endcase
        end
    end

    // Fetch PC register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Resolved-branch and mispredict event counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (res_valid) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_pc_bp.sv
// Testbench for the fetch-PC generator with branch prediction.
// Cycle vectors with expected PCs queued and checked after each edge.
module tb_ysyx_22050854_pc_bp;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam logic [31:0] RST = 32'h8000_0000;

    typedef struct packed {
        logic        stall;
        logic        csr;
        logic [31:0] cpc;
        logic        rv;
        logic        rj;
        logic        rt;
        logic [31:0] rpc;
        logic [31:0] rtgt;
        logic        rpt;
        logic [31:0] rptgt;
        logic [31:0] epc;
        logic        ept;
        logic        efl;
        logic [31:0] enx;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        csr_redirect;
    logic [31:0] csr_pc;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_is_jump;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    int total = 0;
    int bad   = 0;

    vec_t        vecs[$];
    logic [31:0] sb[$];

    ysyx_22050854_pc_bp dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .csr_redirect     (csr_redirect),
        .csr_pc           (csr_pc),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_is_jump      (res_is_jump),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .res_pred_taken   (res_pred_taken),
        .res_pred_target  (res_pred_target),
        .pc               (pc),
        .next_pc          (next_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .flush            (flush),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic st, input logic cs, input logic [31:0] cpc,
        input logic rv, input logic rj, input logic rt,
        input logic [31:0] rpc, input logic [31:0] rtgt,
        input logic rpt, input logic [31:0] rptgt,
        input logic [31:0] epc, input logic ept, input logic efl,
        input logic [31:0] enx);
        vec_t v;
        v = '{stall: st, csr: cs, cpc: cpc, rv: rv, rj: rj, rt: rt,
              rpc: rpc, rtgt: rtgt, rpt: rpt, rptgt: rptgt,
              epc: epc, ept: ept, efl: efl, enx: enx};
        return v;
    endfunction

    function automatic vec_t idl(input logic [31:0] epc,
                                 input logic ept,
                                 input logic [31:0] enx);
        return mk(N, N, 32'h0, N, N, N, 32'h0, 32'h0, N, 32'h0,
                  epc, ept, N, enx);
    endfunction

    function automatic vec_t csr(input logic [31:0] cpc,
                                 input logic [31:0] epc,
                                 input logic ept);
        return mk(N, Y, cpc, N, N, N, 32'h0, 32'h0, N, 32'h0,
                  epc, ept, Y, cpc);
    endfunction

    task automatic apply(input vec_t v);
        stall           = v.stall;
        csr_redirect    = v.csr;
        csr_pc          = v.cpc;
        res_valid       = v.rv;
        res_is_jump     = v.rj;
        res_taken       = v.rt;
        res_pc          = v.rpc;
        res_target      = v.rtgt;
        res_pred_taken  = v.rpt;
        res_pred_target = v.rptgt;
    endtask

    task automatic go_idle();
        apply(idl(32'h0, N, 32'h0));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs.push_back(idl(32'h8000_0000, N, 32'h8000_0004));
        vecs.push_back(idl(32'h8000_0004, N, 32'h8000_0008));
        vecs.push_back(mk(N, N, 32'h0, Y, N, Y, 32'h8000_0010,
            32'h8000_0100, N, 32'h0, 32'h8000_0008, N, Y,
            32'h8000_0100));
        vecs.push_back(idl(32'h8000_0100, N, 32'h8000_0104));
        vecs.push_back(csr(32'h8000_0010, 32'h8000_0104, N));
        vecs.push_back(idl(32'h8000_0010, Y, 32'h8000_0100));
        vecs.push_back(mk(N, N, 32'h0, Y, N, N, 32'h8000_0010,
            32'h0, Y, 32'h8000_0100, 32'h8000_0100, N, Y,
            32'h8000_0014));
        vecs.push_back(mk(N, N, 32'h0, Y, N, N, 32'h8000_0010,
            32'h0, N, 32'h0, 32'h8000_0014, N, N, 32'h8000_0018));
        vecs.push_back(mk(N, N, 32'h0, Y, N, N, 32'h8000_0010,
            32'h0, N, 32'h0, 32'h8000_0018, N, N, 32'h8000_001C));
        vecs.push_back(csr(32'h8000_0010, 32'h8000_001C, N));
        vecs.push_back(idl(32'h8000_0010, N, 32'h8000_0014));
        vecs.push_back(mk(Y, N, 32'h0, N, N, N, 32'h0, 32'h0, N,
            32'h0, 32'h8000_0014, N, N, 32'h8000_0014));
        vecs.push_back(mk(Y, N, 32'h0, Y, N, Y, 32'h8000_0020,
            32'h8000_0200, N, 32'h0, 32'h8000_0014, N, Y,
            32'h8000_0200));
        vecs.push_back(idl(32'h8000_0200, N, 32'h8000_0204));
        vecs.push_back(mk(N, Y, 32'h8000_0400, Y, Y, Y, 32'h8000_0030,
            32'h8000_0300, N, 32'h0, 32'h8000_0204, N, Y,
            32'h8000_0400));
        vecs.push_back(csr(32'h8000_0030, 32'h8000_0400, N));
        vecs.push_back(idl(32'h8000_0030, Y, 32'h8000_0300));
        vecs.push_back(csr(32'h8000_0050, 32'h8000_0300, N));
        vecs.push_back(mk(N, N, 32'h0, Y, N, Y, 32'h8000_0050,
            32'h8000_0500, N, 32'h0, 32'h8000_0050, N, Y,
            32'h8000_0500));
        vecs.push_back(csr(32'h8000_0050, 32'h8000_0500, N));
        vecs.push_back(idl(32'h8000_0050, Y, 32'h8000_0500));
        vecs.push_back(csr(32'hFFFF_FFFC, 32'h8000_0500, N));
        vecs.push_back(idl(32'hFFFF_FFFC, N, 32'h0000_0000));
        vecs.push_back(idl(32'h0000_0000, N, 32'h0000_0004));
        vecs.push_back(mk(N, N, 32'h0, Y, Y, Y, 32'h8000_0030,
            32'h8000_0310, Y, 32'h8000_0300, 32'h0000_0004, N, Y,
            32'h8000_0310));
        vecs.push_back(mk(N, N, 32'h0, Y, Y, Y, 32'h8000_0030,
            32'h8000_0310, Y, 32'h8000_0310, 32'h8000_0310, N, N,
            32'h8000_0314));

        reset = 1'b1;
        go_idle();
        tick();
        chk("rst_pc", pc, RST);
        chk("rst_pt", {31'b0, pred_taken}, 32'h0);
        chk("rst_flush", {31'b0, flush}, 32'h0);
        chk("rst_br", perf_branches, 32'h0);
        chk("rst_mp", perf_mispredicts, 32'h0);
        tick();
        reset = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #3;
            chk($sformatf("r%0d_pc", i), pc, vecs[i].epc);
            chk($sformatf("r%0d_pt", i), {31'b0, pred_taken},
                {31'b0, vecs[i].ept});
            chk($sformatf("r%0d_flush", i), {31'b0, flush},
                {31'b0, vecs[i].efl});
            chk($sformatf("r%0d_npc", i), next_pc, vecs[i].enx);
            if (vecs[i].ept) begin
                chk($sformatf("r%0d_ptgt", i), pred_target, vecs[i].enx);
            end
            sb.push_back(vecs[i].enx);
            tick();
            chk($sformatf("r%0d_sb", i), pc, sb.pop_front());
        end
        go_idle();

        chk("perf_br", perf_branches, 32'd9);
        chk("perf_mp", perf_mispredicts, 32'd6);

        reset = 1'b1;
        csr_redirect = 1'b1;
        csr_pc = 32'h8000_0700;
        res_valid = 1'b1;
        res_taken = 1'b1;
        res_pc = 32'h8000_0060;
        res_target = 32'h8000_0600;
        #3;
        chk("midrst_npc", next_pc, RST);
        tick();
        reset = 1'b0;
        go_idle();
        chk("midrst_pc", pc, RST);
        chk("midrst_br", perf_branches, 32'h0);
        chk("midrst_mp", perf_mispredicts, 32'h0);
        #3;
        chk("midrst_npc2", next_pc, 32'h8000_0004);
        tick();
        chk("post_pc1", pc, 32'h8000_0004);
        tick();
        chk("post_pc2", pc, 32'h8000_0008);

        csr_redirect = 1'b1;
        csr_pc = 32'h8000_0010;
        tick();
        go_idle();
        #3;
        chk("cleared_pc", pc, 32'h8000_0010);
        chk("cleared_pt", {31'b0, pred_taken}, 32'h0);
        tick();

        csr_redirect = 1'b1;
        csr_pc = 32'h8000_0060;
        tick();
        go_idle();
        #3;
        chk("aborted_pc", pc, 32'h8000_0060);
        chk("aborted_pt", {31'b0, pred_taken}, 32'h0);
        chk("aborted_npc", next_pc, 32'h8000_0064);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050854_pc_bp.md
# ysyx_22050854_pc_bp

Parametrised fetch-PC generator with dynamic branch prediction for the ysyx_22050854 pipeline. It holds the architectural fetch PC and predicts the next PC each cycle from a direct-mapped BTB with saturating direction counters. It accepts resolved branch outcomes from the execute-side resolver, redirects and flushes on misprediction, and honours CSR redirects (ecall/mret) and pipeline stalls. It sits in IF, replacing static pc+4 sequencing with a BTB-driven next-PC.

## Interface
- XLEN, 32, PC and target width
- RESET_PC, 32'h8000_0000, PC loaded on reset
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX = log2(BTB_ENTRIES)
- CTR_BITS, 2, direction-counter width (≥1)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC (data conflict or suspend)
- csr_redirect  in  1  ecall/mret redirect request
- csr_pc  in  XLEN  redirect target for csr_redirect
- res_valid  in  1  resolved control-flow instruction this cycle
- res_pc  in  XLEN  PC of the resolved instruction
- res_is_jump  in  1  1 = jal/jalr, 0 = conditional branch
- res_taken  in  1  actual direction
- res_target  in  XLEN  actual taken target
- res_pred_taken  in  1  prediction carried down the pipe with the instruction
- res_pred_target  in  XLEN  predicted target carried down the pipe
- pc  out  XLEN  current fetch PC (registered)
- next_pc  out  XLEN  PC loaded on the next edge
- pred_taken  out  1  prediction for the instruction at pc
- pred_target  out  XLEN  predicted target for pc (valid when pred_taken)
- flush  out  1  mispredict or CSR redirect; squash younger stages
- perf_branches  out  32  resolved control-flow count
- perf_mispredicts  out  32  mispredict count

## Operation
- Lookup (combinational from pc): index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2]. hit = valid & tag match. pred_taken = hit & (is_jump | counter MSB). pred_target = entry target.
- Mispredict: mispredict = res_valid & ((res_taken != res_pred_taken) | (res_taken & res_target != res_pred_target)). Correct PC = res_taken ? res_target : res_pc + 4.
- next_pc priority: reset → RESET_PC; csr_redirect → csr_pc; mispredict → correct PC; stall → pc; pred_taken → pred_target; else pc + 4.
- Redirects (CSR, mispredict) override stall; flush = csr_redirect | mispredict.
- csr_redirect and mispredict in the same cycle: csr_pc wins. The BTB update and perf counters still apply.
- BTB update when res_valid, indexed by res_pc:
  - Taken, miss: allocate. Set valid, tag, target, is_jump; counter = weakly taken (2^(CTR_BITS-1)).
  - Taken, hit: overwrite target and is_jump; counter increments, saturating at 2^CTR_BITS−1.
  - Not taken, hit: counter decrements, saturating at 0.
  - Not taken, miss: no allocation.
- Arithmetic: pc + 4 and res_pc + 4 wrap modulo 2^XLEN. Targets are stored at full XLEN, unmodified.
- Perf: perf_branches increments on res_valid; perf_mispredicts increments on mispredict. Both wrap at 2^32.

## Timing
- Reset values: pc = RESET_PC; all BTB valid = 0; counters = weakly not-taken (2^(CTR_BITS-1)−1); perf counters = 0. Hence pred_taken = 0, and flush = 0 while res_valid = 0 and csr_redirect = 0.
- Reset asserted mid-operation aborts all pending updates that cycle. The first post-reset cycle fetches RESET_PC.
- pred_taken, pred_target, flush and next_pc are combinational in the same cycle. pc takes next_pc at the next edge.
- A BTB write becomes visible to lookup one cycle later. A same-cycle lookup of the written index sees the old contents.
- Redirect latency: flush in cycle N; pc = correct target in cycle N+1.

## Structure
- Package ysyx_22050854_bp_pkg holds:
  - the BTB entry struct (valid, tag, target, is_jump, ctr)
  - counter init constants
  - the redirect-cause enum (NONE, CSR, MISPREDICT)
- Sub-module ysyx_22050854_btb holds:
  - storage, the lookup port and the update/counter logic
  - inputs: lookup pc; update port fields
  - outputs: hit, pred_taken, target
- The top level holds the PC register, the next-PC mux, mispredict detection and the perf counters.

## Test plan
- Reset, no stall, no resolves → pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; pred_taken = 0 throughout.
- Resolve taken branch res_pc = 0x8000_0010, target 0x8000_0100, res_pred_taken = 0 → flush = 1, next cycle pc = 0x8000_0100. On revisiting 0x8000_0010: pred_taken = 1, next_pc = 0x8000_0100.
- Same branch resolved not-taken three times with CTR_BITS = 2 → counter 10→01→00→00 (saturates). From the first decrement, pred_taken = 0 at that PC.
- stall = 1 with a mispredict (res_taken = 1, target 0x8000_0200, res_pred_taken = 0) in the same cycle → flush = 1, pc = 0x8000_0200 next cycle despite stall. stall alone → pc held.
- csr_redirect (csr_pc = 0x8000_0400) and mispredict in the same cycle → pc = 0x8000_0400; BTB still updated; perf_mispredicts + 1.
- Aliasing: BTB_ENTRIES = 16, train 0x8000_0010 taken, then 0x8000_0050 (same index, different tag) → lookup at 0x8000_0050 misses before its own allocation; pc = 0xFFFF_FFFC with no prediction wraps to 0x0000_0000.
